// File: rtl/pipelined_addsub_if.sv
// Stream interface for the pipelined adder/subtractor: operand beat in, result beat out.
// The master drives the operands and out_ready. The slave (the adder) drives the handshake and the result.
interface pipelined_addsub_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, res, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, res, cout, ovf
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/subtract for the PID datapath.
// The carry chain is split into STAGES registered slices, with signed overflow flag, optional saturation and stream flow control.
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4,
  parameter int SAT    = 1
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_addsub_if.slave bus
);
  localparam int SW = WIDTH / STAGES;

  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              c_q [STAGES];
  logic [STAGES-1:0] v_q;

  logic [WIDTH-1:0]  a_n [STAGES];
  logic [WIDTH-1:0]  b_n [STAGES];
  logic [WIDTH-1:0]  s_n [STAGES];
  logic              c_n [STAGES];
  logic [STAGES-1:0] v_n;

  logic [WIDTH-1:0]  b_eff;
  logic [SW:0]       slice;
  logic              c_msb;
  logic              ovf_n;
  logic [WIDTH-1:0]  res_n;
  logic [WIDTH-1:0]  res_q;
  logic              cout_q;
  logic              ovf_q;
  logic              adv;

  function automatic logic [SW:0] slice_add(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                            input logic c);
    return {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, c};
  endfunction

  // One global advance: the whole pipe moves together or holds together.
  assign adv           = bus.out_ready | ~v_q[STAGES-1];
  assign bus.in_ready  = adv;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.res       = res_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  always_comb begin
    b_eff = bus.sub ? ~bus.b : bus.b;
    slice = '0;
    for (int k = 0; k < STAGES; k++) begin
      a_n[k] = '0;
      b_n[k] = '0;
      s_n[k] = '0;
      c_n[k] = 1'b0;
    end
    v_n = '0;

    slice          = slice_add(bus.a[SW-1:0], b_eff[SW-1:0], bus.sub | bus.cin);
    a_n[0]         = bus.a;
    b_n[0]         = b_eff;
    s_n[0][SW-1:0] = slice[SW-1:0];
    c_n[0]         = slice[SW];
    v_n[0]         = bus.in_valid;

    // Each slice takes the carry registered by the previous stage and forwards the lower sum bits.
    for (int k = 1; k < STAGES; k++) begin
      slice                = slice_add(a_q[k-1][k*SW +: SW], b_q[k-1][k*SW +: SW], c_q[k-1]);
      a_n[k]               = a_q[k-1];
      b_n[k]               = b_q[k-1];
      s_n[k]               = s_q[k-1];
      s_n[k][k*SW +: SW]   = slice[SW-1:0];
      c_n[k]               = slice[SW];
      v_n[k]               = v_q[k-1];
    end
  end

  always_comb begin
    c_msb = s_n[STAGES-1][WIDTH-1] ^ a_n[STAGES-1][WIDTH-1] ^ b_n[STAGES-1][WIDTH-1];
    ovf_n = c_msb ^ c_n[STAGES-1];
    res_n = s_n[STAGES-1];
    if ((SAT != 0) && ovf_n) begin
      res_n = a_n[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      v_q    <= '0;
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_n[k];
        b_q[k] <= b_n[k];
        s_q[k] <= s_n[k];
        c_q[k] <= c_n[k];
      end
      v_q    <= v_n;
      res_q  <= res_n;
      cout_q <= c_n[STAGES-1];
      ovf_q  <= ovf_n;
    end
  end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vector table, flow-control sequences, and random traffic against a reference model.
module tb_pipelined_addsub;
  localparam int W  = 16;
  localparam int ST = 4;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [15:0] res_s;
    logic [15:0] res_w;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(W)) bus ();
  pipelined_addsub_if #(.WIDTH(W)) bus_w ();

  pipelined_addsub #(.WIDTH(W), .STAGES(ST), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  pipelined_addsub #(.WIDTH(W), .STAGES(ST), .SAT(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(bus_w.slave)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  op_t  cur_op;
  op_t  exp_q [$];
  vec_t vecs [11];
  bit   in_pat [16];
  bit   out_pat [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: exact signed arithmetic on integers, then wrap or clamp.
  function automatic logic [17:0] model(input op_t op, input bit sat);
    int sa, sb, ua, ub, exact;
    logic c, v;
    logic [15:0] r;
    sa = int'($signed(op.a));
    sb = int'($signed(op.b));
    ua = int'(op.a);
    ub = int'(op.b);
    if (op.sub) begin
      exact = sa - sb;
      c     = (ua >= ub);
    end else begin
      exact = sa + sb + int'(op.cin);
      c     = (ua + ub + int'(op.cin)) > 65535;
    end
    v = (exact > 32767) || (exact < -32768);
    r = exact[15:0];
    if (sat && v) r = (exact > 0) ? 16'h7FFF : 16'h8000;
    return {r, c, v};
  endfunction

  function automatic vec_t mkv(input logic [15:0] a, input logic [15:0] b, input logic sub,
                               input logic cin, input logic [15:0] rs, input logic [15:0] rw,
                               input logic co, input logic ov);
    vec_t v;
    v.op    = '{a: a, b: b, sub: sub, cin: cin};
    v.res_s = rs;
    v.res_w = rw;
    v.cout  = co;
    v.ovf   = ov;
    return v;
  endfunction

  function automatic logic [15:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'hFFFF;
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  task automatic drive(input op_t op, input bit v);
    cur_op         = op;
    bus.a          = op.a;
    bus.b          = op.b;
    bus.sub        = op.sub;
    bus.cin        = op.cin;
    bus.in_valid   = v;
    bus_w.a        = op.a;
    bus_w.b        = op.b;
    bus_w.sub      = op.sub;
    bus_w.cin      = op.cin;
    bus_w.in_valid = v;
  endtask

  task automatic set_ready(input bit r);
    bus.out_ready   = r;
    bus_w.out_ready = r;
  endtask

  // One clock: sample at the falling edge, score, then step past the rising edge.
  task automatic cycle(output bit acc, output bit ov);
    op_t h;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    ov  = bus.out_valid;
    if (bus.out_valid && !bus.out_ready) begin
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      if (exp_q.size() == 0) check("spurious_beat", 32'(bus.out_valid), 32'd0);
      else check("stall_hold", 32'({bus.res, bus.cout, bus.ovf}), 32'(model(exp_q[0], 1'b1)));
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 32'(bus.out_valid), 32'd0);
      end else begin
        h = exp_q.pop_front();
        check("stream_sat", 32'({bus.res, bus.cout, bus.ovf}), 32'(model(h, 1'b1)));
        check("stream_wrap", 32'({bus_w.out_valid, bus_w.res, bus_w.cout, bus_w.ovf}),
              32'({1'b1, model(h, 1'b0)}));
        n_out++;
      end
    end
    if (acc) exp_q.push_back(cur_op);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc, ov, seen;
    int lat, cyc, i, base;
    op_t op;

    vecs[0]  = mkv(16'h1234, 16'h0001, 0, 0, 16'h1235, 16'h1235, 0, 0);
    vecs[1]  = mkv(16'h00FF, 16'h0001, 0, 0, 16'h0100, 16'h0100, 0, 0);
    vecs[2]  = mkv(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 16'h0000, 1, 0);
    vecs[3]  = mkv(16'h0FFF, 16'h0000, 0, 1, 16'h1000, 16'h1000, 0, 0);
    vecs[4]  = mkv(16'h7FFF, 16'h0001, 0, 0, 16'h7FFF, 16'h8000, 0, 1);
    vecs[5]  = mkv(16'h8000, 16'h0001, 1, 0, 16'h8000, 16'h7FFF, 1, 1);
    vecs[6]  = mkv(16'h0005, 16'h0007, 1, 0, 16'hFFFE, 16'hFFFE, 0, 0);
    vecs[7]  = mkv(16'h0010, 16'h0003, 1, 1, 16'h000D, 16'h000D, 1, 0);
    vecs[8]  = mkv(16'h8000, 16'h8000, 0, 0, 16'h8000, 16'h0000, 1, 1);
    vecs[9]  = mkv(16'h0000, 16'h8000, 1, 0, 16'h7FFF, 16'h8000, 0, 1);
    vecs[10] = mkv(16'hFFFF, 16'hFFFF, 0, 1, 16'hFFFF, 16'hFFFF, 1, 0);

    drive('0, 1'b0);
    set_ready(1'b1);
    #12;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_outputs", 32'({bus.out_valid, bus.res, bus.cout, bus.ovf}), 32'd0);
    check("reset_outputs_w", 32'({bus_w.out_valid, bus_w.res, bus_w.cout, bus_w.ovf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      drive(vecs[k].op, 1'b1);
      @(posedge clk);
      #1;
      drive(vecs[k].op, 1'b0);
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check($sformatf("vec%0d_latency", k), 32'(lat), 32'(ST));
      check($sformatf("vec%0d_sat", k), 32'({bus.out_valid, bus.res, bus.cout, bus.ovf}),
            32'({1'b1, vecs[k].res_s, vecs[k].cout, vecs[k].ovf}));
      check($sformatf("vec%0d_wrap", k), 32'({bus_w.out_valid, bus_w.res, bus_w.cout, bus_w.ovf}),
            32'({1'b1, vecs[k].res_w, vecs[k].cout, vecs[k].ovf}));
      @(posedge clk);
      #1;
    end

    // Back-pressure: 8 back-to-back beats, out_ready low for 3 cycles mid-stream.
    i    = 0;
    cyc  = 0;
    base = n_out;
    while ((i < 8 || exp_q.size() > 0) && cyc < 60) begin
      op = '{a: 16'(i), b: 16'(i), sub: 1'b0, cin: 1'b0};
      drive(op, i < 8);
      set_ready(!(cyc >= 5 && cyc < 8));
      cycle(acc, ov);
      if (acc) i++;
      cyc++;
    end
    check("bp_delivered", 32'(n_out - base), 32'd8);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Bubbles: alternating in_valid must reappear at the output four cycles later.
    set_ready(1'b1);
    for (int t = 0; t < 16; t++) begin
      op = '{a: rnd_val(), b: rnd_val(), sub: 1'($urandom_range(0, 1)), cin: 1'($urandom_range(0, 1))};
      drive(op, (t < 8) && (t % 2 == 0));
      cycle(acc, ov);
      in_pat[t]  = acc;
      out_pat[t] = ov;
    end
    for (int t = 0; t < 16; t++) begin
      check($sformatf("bubble_t%0d", t), 32'(out_pat[t]), (t >= ST) ? 32'(in_pat[t-ST]) : 32'd0);
    end

    // Random traffic with random back-pressure.
    for (int t = 0; t < 300; t++) begin
      op = '{a: rnd_val(), b: rnd_val(), sub: 1'($urandom_range(0, 1)), cin: 1'($urandom_range(0, 1))};
      drive(op, $urandom_range(0, 3) != 0);
      set_ready($urandom_range(0, 9) < 7);
      cycle(acc, ov);
    end
    drive('0, 1'b0);
    set_ready(1'b1);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      cycle(acc, ov);
      cyc++;
    end
    check("random_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-flight: three beats in the pipe, first one stalled at the output.
    set_ready(1'b0);
    for (int k = 0; k < 3; k++) begin
      op = '{a: 16'(16'h1111 * (k + 1)), b: 16'hF000, sub: 1'b0, cin: 1'b0};
      drive(op, 1'b1);
      cycle(acc, ov);
    end
    drive('0, 1'b0);
    cyc = 0;
    while (!bus.out_valid && cyc < 10) begin
      cycle(acc, ov);
      cyc++;
    end
    check("rst_pre_valid", 32'({bus.out_valid, bus.res, bus.cout}), 32'({1'b1, 16'h0111, 1'b1}));
    rst_n = 1'b0;
    #2;
    check("rst_async_clear", 32'({bus.out_valid, bus.res, bus.cout, bus.ovf}), 32'd0);
    check("rst_async_clear_w", 32'({bus_w.out_valid, bus_w.res, bus_w.cout, bus_w.ovf}), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    #2;
    rst_n = 1'b1;
    exp_q.delete();
    set_ready(1'b1);
    seen = 1'b0;
    for (int t = 0; t < 12; t++) begin
      cycle(acc, ov);
      seen = seen | ov | bus_w.out_valid;
    end
    check("rst_no_leftover", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
